// File: rtl/ipsl_pcie_dma_tx_arb_if.sv
// ---------------------------------------------------------------------------
// ipsl_pcie_dma_tx_arb_if
//   Bundle of the three DMA TX source streams, the PCIe core TX stream and
//   the arbiter debug outputs.
//   slave  : arbiter view (consumes source streams, drives the core stream,
//            grant, per-source TLP counters and the stall flag).
//   master : environment view (sources, core ready, debug readout).
// ---------------------------------------------------------------------------
interface ipsl_pcie_dma_tx_arb_if #(
  parameter int DATA_WIDTH = 128,
  parameter int CNT_WIDTH  = 16
);
  logic                  i_s0_tvld, i_s1_tvld, i_s2_tvld;
  logic [DATA_WIDTH-1:0] i_s0_tdata, i_s1_tdata, i_s2_tdata;
  logic                  i_s0_tlast, i_s1_tlast, i_s2_tlast;
  logic                  i_s0_tuser, i_s1_tuser, i_s2_tuser;
  logic                  o_s0_trdy, o_s1_trdy, o_s2_trdy;
  logic                  i_m_trdy;
  logic                  o_m_tvld;
  logic [DATA_WIDTH-1:0] o_m_tdata;
  logic                  o_m_tlast;
  logic                  o_m_tuser;
  logic [2:0]            o_grant;
  logic [CNT_WIDTH-1:0]  o_tlp_cnt0, o_tlp_cnt1, o_tlp_cnt2;
  logic                  o_stall_err;

  modport slave (
    input  i_s0_tvld, i_s1_tvld, i_s2_tvld,
    input  i_s0_tdata, i_s1_tdata, i_s2_tdata,
    input  i_s0_tlast, i_s1_tlast, i_s2_tlast,
    input  i_s0_tuser, i_s1_tuser, i_s2_tuser,
    output o_s0_trdy, o_s1_trdy, o_s2_trdy,
    input  i_m_trdy,
    output o_m_tvld, o_m_tdata, o_m_tlast, o_m_tuser,
    output o_grant, o_tlp_cnt0, o_tlp_cnt1, o_tlp_cnt2, o_stall_err
  );

  modport master (
    output i_s0_tvld, i_s1_tvld, i_s2_tvld,
    output i_s0_tdata, i_s1_tdata, i_s2_tdata,
    output i_s0_tlast, i_s1_tlast, i_s2_tlast,
    output i_s0_tuser, i_s1_tuser, i_s2_tuser,
    input  o_s0_trdy, o_s1_trdy, o_s2_trdy,
    output i_m_trdy,
    input  o_m_tvld, o_m_tdata, o_m_tlast, o_m_tuser,
    input  o_grant, o_tlp_cnt0, o_tlp_cnt1, o_tlp_cnt2, o_stall_err
  );
endinterface

// File: rtl/ipsl_pcie_dma_tx_arb.sv
// ---------------------------------------------------------------------------
// ipsl_pcie_dma_tx_arb
//   Packet-granular arbiter merging the CPLD (0), MRD (1) and MWR (2) DMA TX
//   streams into the PCIe core TX stream. A grant is held from arbitration
//   until the tlast beat is accepted; the output passes through one register.
//   Ports:
//     clk, rst_n    : user clock, asynchronous active-low reset
//     i_tx_restart  : synchronous clear of TLP counters and stall flag
//     bus (slave)   : source streams, core stream, o_grant, o_tlp_cnt0..2,
//                     o_stall_err
//   Build option:
//     IPSL_PCIE_TX_ARB_CPLD_PRIO_EN : source 0 wins whenever it requests,
//     sources 1/2 round-robin between themselves. Undefined: 3-way RR.
// ---------------------------------------------------------------------------
module ipsl_pcie_dma_tx_arb #(
  parameter int DATA_WIDTH  = 128,
  parameter int CNT_WIDTH   = 16,
  parameter int STALL_LIMIT = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_tx_restart,
  ipsl_pcie_dma_tx_arb_if.slave  bus
);

  localparam int STALL_W = $clog2(STALL_LIMIT + 1);
  localparam logic [STALL_W-1:0] STALL_MAX  = STALL_W'(STALL_LIMIT);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_LIMIT - 1);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t                state;
  logic [2:0]            grant;
  logic [1:0]            ptr;
  logic [STALL_W-1:0]    stall_cnt;
  logic                  stall_err;
  logic [CNT_WIDTH-1:0]  tlp_cnt [3];

  logic                  tvld_p1, tlast_p1, tuser_p1;
  logic [DATA_WIDTH-1:0] tdata_p1;

  logic [2:0]            req;
  logic                  sel_vld, sel_last, sel_user;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  out_rdy, acc;

  assign req = {bus.i_s2_tvld, bus.i_s1_tvld, bus.i_s0_tvld};

  // Plain round-robin: first requester found starting at the pointer.
  function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [1:0] p);
    logic [2:0] g;
    int         idx;
    g = 3'b000;
    for (int k = 0; k < 3; k++) begin
      idx = (int'(p) + k) % 3;
      if (r[idx] && g == 3'b000) g[idx] = 1'b1;
    end
    return g;
  endfunction

  function automatic logic [2:0] arb_pick(input logic [2:0] r, input logic [1:0] p);
`ifdef IPSL_PCIE_TX_ARB_CPLD_PRIO_EN
    // Completions first to avoid requester-side completion timeouts.
    if (r[0]) return 3'b001;
    return rr_pick(r & 3'b110, p);
`else
    return rr_pick(r, p);
`endif
  endfunction

  // Pointer moves to the source after the winner.
  function automatic logic [1:0] ptr_next(input logic [2:0] g, input logic [1:0] p);
    logic [1:0] n;
    n = p;
    if (g[1]) n = 2'd2;
    if (g[2]) n = 2'd0;
`ifndef IPSL_PCIE_TX_ARB_CPLD_PRIO_EN
    if (g[0]) n = 2'd1;
`endif
    return n;
  endfunction

  always_comb begin
    sel_vld  = 1'b0;
    sel_last = 1'b0;
    sel_user = 1'b0;
    sel_data = '0;
    unique case (grant)
      3'b001: begin
        sel_vld = bus.i_s0_tvld; sel_last = bus.i_s0_tlast;
        sel_user = bus.i_s0_tuser; sel_data = bus.i_s0_tdata;
      end
      3'b010: begin
        sel_vld = bus.i_s1_tvld; sel_last = bus.i_s1_tlast;
        sel_user = bus.i_s1_tuser; sel_data = bus.i_s1_tdata;
      end
      3'b100: begin
        sel_vld = bus.i_s2_tvld; sel_last = bus.i_s2_tlast;
        sel_user = bus.i_s2_tuser; sel_data = bus.i_s2_tdata;
      end
      default: ;
    endcase
  end

  // Output register can take a beat when empty or draining this cycle.
  assign out_rdy = ~tvld_p1 | bus.i_m_trdy;
  // grant is only non-zero in LOCK, so no beat is taken while arbitrating.
  assign acc     = sel_vld & out_rdy;

  assign bus.o_s0_trdy = grant[0] & out_rdy;
  assign bus.o_s1_trdy = grant[1] & out_rdy;
  assign bus.o_s2_trdy = grant[2] & out_rdy;

  // Arbitration / grant FSM, stall supervision and TLP counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant     <= 3'b000;
      ptr       <= 2'd0;
      stall_cnt <= '0;
      stall_err <= 1'b0;
      for (int i = 0; i < 3; i++) tlp_cnt[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          stall_cnt <= '0;
          if (|req) begin
            grant <= arb_pick(req, ptr);
            state <= LOCK;
          end
        end
        LOCK: begin
          if (acc) begin
            stall_cnt <= '0;
            if (sel_last) begin
              grant <= 3'b000;
              ptr   <= ptr_next(grant, ptr);
              state <= IDLE;
            end
          end else if (!sel_vld && stall_cnt != STALL_MAX) begin
            stall_cnt <= stall_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // Restart clear takes precedence over a same-cycle increment or flag.
      if (i_tx_restart) begin
        stall_err <= 1'b0;
        for (int i = 0; i < 3; i++) tlp_cnt[i] <= '0;
      end else begin
        if (state == LOCK && !sel_vld && stall_cnt == STALL_LAST) stall_err <= 1'b1;
        for (int i = 0; i < 3; i++)
          if (acc && sel_last && grant[i]) tlp_cnt[i] <= tlp_cnt[i] + 1'b1;
      end
    end
  end

  // Stage p1: output register towards the PCIe core
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tvld_p1  <= 1'b0;
      tlast_p1 <= 1'b0;
      tuser_p1 <= 1'b0;
      tdata_p1 <= '0;
    end else if (acc) begin
      tvld_p1  <= 1'b1;
      tlast_p1 <= sel_last;
      tuser_p1 <= sel_user;
      tdata_p1 <= sel_data;
    end else if (bus.i_m_trdy) begin
      tvld_p1  <= 1'b0;
    end
  end

  assign bus.o_m_tvld    = tvld_p1;
  assign bus.o_m_tdata   = tdata_p1;
  assign bus.o_m_tlast   = tlast_p1;
  assign bus.o_m_tuser   = tuser_p1;
  assign bus.o_grant     = grant;
  assign bus.o_tlp_cnt0  = tlp_cnt[0];
  assign bus.o_tlp_cnt1  = tlp_cnt[1];
  assign bus.o_tlp_cnt2  = tlp_cnt[2];
  assign bus.o_stall_err = stall_err;

endmodule

// File: tb/tb_ipsl_pcie_dma_tx_arb.sv
module tb_ipsl_pcie_dma_tx_arb;
  localparam int DW  = 128;
  localparam int CW  = 16;
  localparam int SL  = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_tx_restart = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ipsl_pcie_dma_tx_arb_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  ipsl_pcie_dma_tx_arb #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .STALL_LIMIT(SL)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_tx_restart (i_tx_restart),
    .bus          (bus)
  );

  typedef struct {
    logic       rst;
    logic [2:0] vld;
    logic [2:0] last;
    logic [7:0] d0, d1, d2;
    logic       m_trdy;
    logic [2:0] e_grant;
    logic [2:0] e_trdy;
    logic       e_mvld;
    logic [7:0] e_mdata;
    logic       e_mlast;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] vld, input logic [2:0] last,
                       input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                       input logic m_trdy);
    bus.i_s0_tvld  = vld[0];  bus.i_s1_tvld  = vld[1];  bus.i_s2_tvld  = vld[2];
    bus.i_s0_tlast = last[0]; bus.i_s1_tlast = last[1]; bus.i_s2_tlast = last[2];
    bus.i_s0_tdata = DW'(d0); bus.i_s1_tdata = DW'(d1); bus.i_s2_tdata = DW'(d2);
    bus.i_s0_tuser = d0[0];   bus.i_s1_tuser = d1[0];   bus.i_s2_tuser = d2[0];
    bus.i_m_trdy   = m_trdy;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(3'b000, 3'b000, 8'h0, 8'h0, 8'h0, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic add(input logic rst, input logic [2:0] vld, input logic [2:0] last,
                     input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                     input logic m_trdy, input logic [2:0] eg, input logic [2:0] et,
                     input logic ev, input logic [7:0] ed, input logic el);
    vec_t v;
    v.rst = rst; v.vld = vld; v.last = last; v.d0 = d0; v.d1 = d1; v.d2 = d2;
    v.m_trdy = m_trdy; v.e_grant = eg; v.e_trdy = et; v.e_mvld = ev;
    v.e_mdata = ed; v.e_mlast = el;
    vecs.push_back(v);
  endtask

  // Inputs go in on the falling edge; outputs are sampled 1 ns later and
  // reflect every rising edge before this vector plus combinational trdy.
  task automatic run_table(input string tag);
    vec_t v;
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      if (v.rst) do_reset();
      @(negedge clk);
      drive(v.vld, v.last, v.d0, v.d1, v.d2, v.m_trdy);
      #1;
      chk($sformatf("%s[%0d] grant", tag, i), DW'(bus.o_grant), DW'(v.e_grant));
      chk($sformatf("%s[%0d] trdy", tag, i),
          DW'({bus.o_s2_trdy, bus.o_s1_trdy, bus.o_s0_trdy}), DW'(v.e_trdy));
      chk($sformatf("%s[%0d] m_tvld", tag, i), DW'(bus.o_m_tvld), DW'(v.e_mvld));
      if (v.e_mvld) begin
        chk($sformatf("%s[%0d] m_tdata", tag, i), bus.o_m_tdata, DW'(v.e_mdata));
        chk($sformatf("%s[%0d] m_tlast", tag, i), DW'(bus.o_m_tlast), DW'(v.e_mlast));
        chk($sformatf("%s[%0d] m_tuser", tag, i), DW'(bus.o_m_tuser), DW'(v.e_mdata[0]));
      end
    end
    vecs.delete();
  endtask

  initial begin
    drive(3'b000, 3'b000, 8'h0, 8'h0, 8'h0, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state and a 4-beat TLP from source 1.
    add(0, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 1, 3'b000, 3'b000, 0, 8'h00, 0);
    add(0, 3'b010, 3'b000, 8'h00, 8'h01, 8'h00, 1, 3'b000, 3'b000, 0, 8'h00, 0);
    add(0, 3'b010, 3'b000, 8'h00, 8'h01, 8'h00, 1, 3'b010, 3'b010, 0, 8'h00, 0);
    add(0, 3'b010, 3'b000, 8'h00, 8'h02, 8'h00, 1, 3'b010, 3'b010, 1, 8'h01, 0);
    add(0, 3'b010, 3'b000, 8'h00, 8'h03, 8'h00, 1, 3'b010, 3'b010, 1, 8'h02, 0);
    add(0, 3'b010, 3'b010, 8'h00, 8'h04, 8'h00, 1, 3'b010, 3'b010, 1, 8'h03, 0);
    add(0, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 1, 3'b000, 3'b000, 1, 8'h04, 1);
    add(0, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 1, 3'b000, 3'b000, 0, 8'h00, 0);
    run_table("s1_tlp");
    chk("cnt0 after s1", DW'(bus.o_tlp_cnt0), DW'(0));
    chk("cnt1 after s1", DW'(bus.o_tlp_cnt1), DW'(1));
    chk("stall_err idle", DW'(bus.o_stall_err), DW'(0));

    // All three sources offering single-beat TLPs, then only sources 1/2.
    add(1, 3'b111, 3'b111, 8'h10, 8'h20, 8'h30, 1, 3'b000, 3'b000, 0, 8'h00, 0);
`ifdef IPSL_PCIE_TX_ARB_CPLD_PRIO_EN
    for (int k = 0; k < 4; k++) begin
      add(0, 3'b111, 3'b111, 8'h10, 8'h20, 8'h30, 1, 3'b001, 3'b001, 0, 8'h00, 0);
      add(0, 3'b111, 3'b111, 8'h10, 8'h20, 8'h30, 1, 3'b000, 3'b000, 1, 8'h10, 1);
    end
    add(0, 3'b111, 3'b111, 8'h10, 8'h20, 8'h30, 1, 3'b001, 3'b001, 0, 8'h00, 0);
    add(0, 3'b110, 3'b111, 8'h10, 8'h20, 8'h30, 1, 3'b000, 3'b000, 1, 8'h10, 1);
    add(0, 3'b110, 3'b111, 8'h10, 8'h20, 8'h30, 1, 3'b010, 3'b010, 0, 8'h00, 0);
    add(0, 3'b110, 3'b111, 8'h10, 8'h20, 8'h30, 1, 3'b000, 3'b000, 1, 8'h20, 1);
    add(0, 3'b110, 3'b111, 8'h10, 8'h20, 8'h30, 1, 3'b100, 3'b100, 0, 8'h00, 0);
    add(0, 3'b110, 3'b111, 8'h10, 8'h20, 8'h30, 1, 3'b000, 3'b000, 1, 8'h30, 1);
    add(0, 3'b110, 3'b111, 8'h10, 8'h20, 8'h30, 1, 3'b010, 3'b010, 0, 8'h00, 0);
`else
    add(0, 3'b111, 3'b111, 8'h10, 8'h20, 8'h30, 1, 3'b001, 3'b001, 0, 8'h00, 0);
    add(0, 3'b111, 3'b111, 8'h10, 8'h20, 8'h30, 1, 3'b000, 3'b000, 1, 8'h10, 1);
    add(0, 3'b111, 3'b111, 8'h10, 8'h20, 8'h30, 1, 3'b010, 3'b010, 0, 8'h00, 0);
    add(0, 3'b111, 3'b111, 8'h10, 8'h20, 8'h30, 1, 3'b000, 3'b000, 1, 8'h20, 1);
    add(0, 3'b111, 3'b111, 8'h10, 8'h20, 8'h30, 1, 3'b100, 3'b100, 0, 8'h00, 0);
    add(0, 3'b111, 3'b111, 8'h10, 8'h20, 8'h30, 1, 3'b000, 3'b000, 1, 8'h30, 1);
    add(0, 3'b111, 3'b111, 8'h10, 8'h20, 8'h30, 1, 3'b001, 3'b001, 0, 8'h00, 0);
    add(0, 3'b111, 3'b111, 8'h10, 8'h20, 8'h30, 1, 3'b000, 3'b000, 1, 8'h10, 1);
    add(0, 3'b111, 3'b111, 8'h10, 8'h20, 8'h30, 1, 3'b010, 3'b010, 0, 8'h00, 0);
    add(0, 3'b110, 3'b111, 8'h10, 8'h20, 8'h30, 1, 3'b000, 3'b000, 1, 8'h20, 1);
    add(0, 3'b110, 3'b111, 8'h10, 8'h20, 8'h30, 1, 3'b100, 3'b100, 0, 8'h00, 0);
    add(0, 3'b110, 3'b111, 8'h10, 8'h20, 8'h30, 1, 3'b000, 3'b000, 1, 8'h30, 1);
    add(0, 3'b110, 3'b111, 8'h10, 8'h20, 8'h30, 1, 3'b010, 3'b010, 0, 8'h00, 0);
    add(0, 3'b110, 3'b111, 8'h10, 8'h20, 8'h30, 1, 3'b000, 3'b000, 1, 8'h20, 1);
    add(0, 3'b110, 3'b111, 8'h10, 8'h20, 8'h30, 1, 3'b100, 3'b100, 0, 8'h00, 0);
`endif
    run_table("rr");

    // Core back-pressure for 3 cycles during a 4-beat source-2 TLP.
    add(1, 3'b100, 3'b000, 8'h00, 8'h00, 8'h01, 1, 3'b000, 3'b000, 0, 8'h00, 0);
    add(0, 3'b100, 3'b000, 8'h00, 8'h00, 8'h01, 1, 3'b100, 3'b100, 0, 8'h00, 0);
    add(0, 3'b100, 3'b000, 8'h00, 8'h00, 8'h02, 1, 3'b100, 3'b100, 1, 8'h01, 0);
    add(0, 3'b100, 3'b000, 8'h00, 8'h00, 8'h03, 0, 3'b100, 3'b000, 1, 8'h02, 0);
    add(0, 3'b100, 3'b000, 8'h00, 8'h00, 8'h03, 0, 3'b100, 3'b000, 1, 8'h02, 0);
    add(0, 3'b100, 3'b000, 8'h00, 8'h00, 8'h03, 0, 3'b100, 3'b000, 1, 8'h02, 0);
    add(0, 3'b100, 3'b000, 8'h00, 8'h00, 8'h03, 1, 3'b100, 3'b100, 1, 8'h02, 0);
    add(0, 3'b100, 3'b100, 8'h00, 8'h00, 8'h04, 1, 3'b100, 3'b100, 1, 8'h03, 0);
    add(0, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 1, 3'b000, 3'b000, 1, 8'h04, 1);
    add(0, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 1, 3'b000, 3'b000, 0, 8'h00, 0);
    run_table("bp");
    chk("cnt2 after bp", DW'(bus.o_tlp_cnt2), DW'(1));

    // Source 2 stalls mid-TLP while source 0 requests.
    @(negedge clk); drive(3'b100, 3'b000, 8'h00, 8'h00, 8'h55, 1'b1);
    @(negedge clk); #1;
    chk("stall grant", DW'(bus.o_grant), DW'(3'b100));
    @(negedge clk); drive(3'b001, 3'b001, 8'h77, 8'h00, 8'h00, 1'b1);
    repeat (SL - 1) @(negedge clk);
    #1;
    chk("stall_err before limit", DW'(bus.o_stall_err), DW'(0));
    @(negedge clk); #1;
    chk("stall_err at limit", DW'(bus.o_stall_err), DW'(1));
    chk("stall grant held", DW'(bus.o_grant), DW'(3'b100));
    chk("stall s0 trdy", DW'(bus.o_s0_trdy), DW'(0));
    @(negedge clk); #1;
    chk("stall_err sticky", DW'(bus.o_stall_err), DW'(1));
    i_tx_restart = 1'b1;
    @(negedge clk); i_tx_restart = 1'b0; #1;
    chk("restart stall_err", DW'(bus.o_stall_err), DW'(0));
    chk("restart cnt2", DW'(bus.o_tlp_cnt2), DW'(0));
    chk("restart cnt1", DW'(bus.o_tlp_cnt1), DW'(0));
    chk("restart grant", DW'(bus.o_grant), DW'(3'b100));

    // Restart coinciding with the tlast acceptance: clear wins.
    @(negedge clk); drive(3'b101, 3'b101, 8'h77, 8'h00, 8'h66, 1'b1); i_tx_restart = 1'b1;
    @(negedge clk); drive(3'b001, 3'b001, 8'h77, 8'h00, 8'h00, 1'b1); i_tx_restart = 1'b0; #1;
    chk("restart+last cnt2", DW'(bus.o_tlp_cnt2), DW'(0));
    chk("restart+last grant", DW'(bus.o_grant), DW'(3'b000));
    chk("restart+last data", bus.o_m_tdata, DW'(8'h66));
    @(negedge clk); #1;
    chk("s0 after stall grant", DW'(bus.o_grant), DW'(3'b001));
    @(negedge clk); drive(3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 1'b1); #1;
    chk("s0 after stall cnt0", DW'(bus.o_tlp_cnt0), DW'(1));
    chk("s0 after stall data", bus.o_m_tdata, DW'(8'h77));

    // Asynchronous reset in the middle of a 4-beat source-1 TLP.
    @(negedge clk); drive(3'b010, 3'b000, 8'h00, 8'h01, 8'h00, 1'b1);
    @(negedge clk);
    @(negedge clk); drive(3'b010, 3'b000, 8'h00, 8'h02, 8'h00, 1'b1);
    @(negedge clk); drive(3'b010, 3'b000, 8'h00, 8'h03, 8'h00, 1'b1); #1;
    chk("pre-rst m_tdata", bus.o_m_tdata, DW'(8'h02));
    #2 rst_n = 1'b0;
    #1;
    chk("async rst m_tvld", DW'(bus.o_m_tvld), DW'(0));
    chk("async rst grant", DW'(bus.o_grant), DW'(3'b000));
    chk("async rst s1 trdy", DW'(bus.o_s1_trdy), DW'(0));
    chk("async rst cnt0", DW'(bus.o_tlp_cnt0), DW'(0));
    drive(3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 1'b1);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); drive(3'b001, 3'b001, 8'h05, 8'h00, 8'h00, 1'b1); #1;
    chk("post-rst arb cycle grant", DW'(bus.o_grant), DW'(3'b000));
    @(negedge clk); #1;
    chk("post-rst grant", DW'(bus.o_grant), DW'(3'b001));
    chk("post-rst s0 trdy", DW'(bus.o_s0_trdy), DW'(1));
    @(negedge clk); drive(3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 1'b1); #1;
    chk("post-rst m_tdata", bus.o_m_tdata, DW'(8'h05));
    chk("post-rst cnt0", DW'(bus.o_tlp_cnt0), DW'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
